// File: rtl/seg_scan_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: FSM state
// encoding and the width of the brightness PWM phase.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    localparam int PWM_W = 4;

endpackage

// File: rtl/seg_slot_timer.sv
// Digit-slot timer: reloads to SLOT-1 and counts down while the scanner runs,
// flagging the last blank cycle and the last cycle of the slot.
module seg_slot_timer #(
    parameter int SLOT         = 10,
    parameter int BLANK_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_blank_end,
    output logic o_slot_end
);

    localparam int            CW       = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam logic [CW-1:0] LOAD     = CW'(SLOT - 1);
    localparam logic [CW-1:0] BLANK_TC = CW'(SLOT - BLANK_CYCLES);

    logic [CW-1:0] r_cnt;
    logic          w_tc;

    assign w_tc = (r_cnt == '0);

    // Idle keeps the counter preloaded so the first active cycle is slot cycle 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!i_run || w_tc) begin
            r_cnt <= LOAD;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_slot_end  = i_run && w_tc;
    assign o_blank_end = (BLANK_CYCLES > 0) && i_run && (r_cnt == BLANK_TC);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed segment-display scanner with per-slot anti-ghost blanking.
// Optional brightness PWM is enabled by defining SEG_SCAN_BRIGHTNESS_EN.
//
// state    | meaning
// ST_IDLE  | no digit enabled; select inactive, data 0
// ST_BLANK | start of slot; select inactive, data 0
// ST_SHOW  | selected digit driven with the byte latched on entry
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int FREQUENCY_IN  = 50_000_000,
    parameter int SLOT_HZ       = 1000,
    parameter int DIGITS        = 4,
    parameter int BLANK_CYCLES  = 50,
    parameter int CS_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef SEG_SCAN_BRIGHTNESS_EN
    input  logic [PWM_W-1:0]      brightness_in,
`endif
    input  logic [DIGITS-1:0]     digit_en_in,
    input  logic [8*DIGITS-1:0]   seg_data_in,
    output logic [DIGITS-1:0]     seg_cs_out,
    output logic [7:0]            seg_data_out,
    output logic                  frame_tick_out
);

    localparam int              SLOT   = FREQUENCY_IN / SLOT_HZ;
    localparam int              IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS-1:0] CS_OFF = (CS_ACTIVE_LOW != 0) ? '1 : '0;

    scan_state_t       r_state, w_state_nx;
    logic [IW-1:0]     r_idx, w_idx_nx, w_low_idx, w_next_idx;
    logic [DIGITS-1:0] r_cs, w_cs_nx;
    logic [7:0]        r_data, w_data_nx;
    logic              r_tick, w_tick_nx;
    logic              w_show_entry, w_lit, w_any, w_wrap, w_run;
    logic              w_blank_end, w_slot_end;

    // First enabled index strictly after cur, circularly; cur itself is the last candidate.
    function automatic logic [IW-1:0] f_next_en(input logic [DIGITS-1:0] mask,
                                                input logic [IW-1:0]     cur);
        logic [IW-1:0] res;
        logic [IW-1:0] jj;
        int            j;
        res = cur;
        for (int k = DIGITS; k >= 1; k--) begin
            j  = (int'(cur) + k) % DIGITS;
            jj = IW'(j);
            if (mask[jj]) res = jj;
        end
        return res;
    endfunction

    assign w_any      = |digit_en_in;
    assign w_low_idx  = f_next_en(digit_en_in, IW'(DIGITS - 1));
    assign w_next_idx = f_next_en(digit_en_in, r_idx);
    assign w_wrap     = (w_next_idx <= r_idx);
    assign w_run      = (r_state != ST_IDLE);

    seg_slot_timer #(
        .SLOT         (SLOT),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk         (clk),
        .rst         (rst),
        .i_run       (w_run),
        .o_blank_end (w_blank_end),
        .o_slot_end  (w_slot_end)
    );

    always_comb begin
        w_state_nx   = r_state;
        w_idx_nx     = r_idx;
        w_tick_nx    = 1'b0;
        w_show_entry = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_idx_nx = w_low_idx;
                    if (BLANK_CYCLES == 0) begin
                        w_state_nx   = ST_SHOW;
                        w_show_entry = 1'b1;
                    end else begin
                        w_state_nx = ST_BLANK;
                    end
                end
            end
            ST_BLANK: begin
                if (w_blank_end) begin
                    w_state_nx   = ST_SHOW;
                    w_show_entry = 1'b1;
                end
            end
            ST_SHOW: begin
                if (w_slot_end) begin
                    if (!w_any) begin
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_idx_nx  = w_next_idx;
                        w_tick_nx = w_wrap;
                        if (BLANK_CYCLES == 0) begin
                            w_show_entry = 1'b1;
                        end else begin
                            w_state_nx = ST_BLANK;
                        end
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

`ifdef SEG_SCAN_BRIGHTNESS_EN
    logic [PWM_W-1:0] r_pwm, r_bright, w_pwm_nx, w_bright_nx;

    // Phase restarts at every SHOW entry so each digit gets the same duty pattern.
    always_comb begin
        w_pwm_nx    = w_show_entry ? '0 : r_pwm + 1'b1;
        w_bright_nx = w_show_entry ? brightness_in : r_bright;
        w_lit       = (w_pwm_nx < w_bright_nx);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pwm    <= '0;
            r_bright <= '0;
        end else begin
            r_pwm    <= w_pwm_nx;
            r_bright <= w_bright_nx;
        end
    end
`else
    assign w_lit = 1'b1;
`endif

    always_comb begin
        w_data_nx = 8'h00;
        w_cs_nx   = CS_OFF;
        if (w_state_nx == ST_SHOW) begin
            w_data_nx = w_show_entry ? seg_data_in[8*w_idx_nx +: 8] : r_data;
            if (w_lit) w_cs_nx = CS_OFF ^ (DIGITS'(1) << w_idx_nx);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cs    <= CS_OFF;
            r_data  <= 8'h00;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_cs    <= w_cs_nx;
            r_data  <= w_data_nx;
            r_tick  <= w_tick_nx;
        end
    end

    assign seg_cs_out     = r_cs;
    assign seg_data_out   = r_data;
    assign frame_tick_out = r_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: an active-high/blanking instance and an
// active-low/no-blank instance, checked every cycle against a slot-level model.
module tb_seg_scan_ctrl;

    localparam int FREQ  = 1000;
    localparam int SHZ   = 100;
    localparam int SLOT  = FREQ / SHZ;
`ifdef SEG_SCAN_BRIGHTNESS_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [3:0]  bright;
    logic [3:0]  cs_a, cs_b;
    logic [7:0]  dat_a, dat_b;
    logic        tk_a, tk_b;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int ticks_a = 0;
    int act_a = 0;
    int act_b = 0;
    int t0;

    // Model: per unit, whether a slot is running, which digit, and the slot age.
    bit       m_busy [2];
    int       m_idx  [2];
    int       m_age  [2];
    bit [7:0] m_data [2];
    bit       m_tick [2];
    int       m_br   [2];

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .FREQUENCY_IN (FREQ), .SLOT_HZ (SHZ), .DIGITS (4),
        .BLANK_CYCLES (2), .CS_ACTIVE_LOW (0)
    ) u_dut_a (
        .clk            (clk),
        .rst            (rst),
`ifdef SEG_SCAN_BRIGHTNESS_EN
        .brightness_in  (bright),
`endif
        .digit_en_in    (mask),
        .seg_data_in    (data),
        .seg_cs_out     (cs_a),
        .seg_data_out   (dat_a),
        .frame_tick_out (tk_a)
    );

    seg_scan_ctrl #(
        .FREQUENCY_IN (FREQ), .SLOT_HZ (SHZ), .DIGITS (4),
        .BLANK_CYCLES (0), .CS_ACTIVE_LOW (1)
    ) u_dut_b (
        .clk            (clk),
        .rst            (rst),
`ifdef SEG_SCAN_BRIGHTNESS_EN
        .brightness_in  (bright),
`endif
        .digit_en_in    (mask),
        .seg_data_in    (data),
        .seg_cs_out     (cs_b),
        .seg_data_out   (dat_b),
        .frame_tick_out (tk_b)
    );

    function automatic int blk_of(input int u);
        return (u == 0) ? 2 : 0;
    endfunction

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int next_after(input logic [3:0] m, input int cur);
        for (int i = cur + 1; i < 4; i++) if (m[i]) return i;
        return lowest(m);
    endfunction

    function automatic bit exp_show(input int u);
        return m_busy[u] && (m_age[u] >= blk_of(u));
    endfunction

    function automatic logic [3:0] exp_cs(input int u);
        logic [3:0] on;
        bit         lit;
        lit = exp_show(u) && (!BR_EN || (((m_age[u] - blk_of(u)) % 16) < m_br[u]));
        on  = lit ? 4'(1 << m_idx[u]) : 4'b0000;
        return (u == 1) ? ~on : on;
    endfunction

    function automatic logic [7:0] exp_data(input int u);
        return exp_show(u) ? m_data[u] : 8'h00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            for (int u = 0; u < 2; u++) begin
                if (!rst) begin
                    m_busy[u] = 1'b0; m_idx[u] = 0; m_age[u] = 0;
                    m_data[u] = 8'h00; m_tick[u] = 1'b0; m_br[u] = 0;
                end else begin
                    m_tick[u] = 1'b0;
                    if (!m_busy[u]) begin
                        if (mask != 4'b0000) begin
                            m_busy[u] = 1'b1;
                            m_idx[u]  = lowest(mask);
                            m_age[u]  = 0;
                        end
                    end else if (m_age[u] == SLOT - 1) begin
                        if (mask == 4'b0000) begin
                            m_busy[u] = 1'b0;
                        end else begin
                            int n;
                            n = next_after(mask, m_idx[u]);
                            m_tick[u] = (n <= m_idx[u]);
                            m_idx[u]  = n;
                            m_age[u]  = 0;
                        end
                    end else begin
                        m_age[u]++;
                    end
                    if (m_busy[u] && m_age[u] == blk_of(u)) begin
                        m_data[u] = data[8*m_idx[u] +: 8];
                        m_br[u]   = int'(bright);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (chk_en) begin
                check("cs_a",    cs_a,  exp_cs(0));
                check("data_a",  dat_a, exp_data(0));
                check("tick_a",  tk_a,  m_tick[0]);
                check("onehot_a", ($countones(cs_a) <= 1), 1);
                check("cs_b",    cs_b,  exp_cs(1));
                check("data_b",  dat_b, exp_data(1));
                check("tick_b",  tk_b,  m_tick[1]);
                check("onehot_b", ($countones(~cs_b) <= 1), 1);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (tk_a) ticks_a++;
            if (cs_a != 4'b0000) act_a++;
            if (cs_b != 4'b1111) act_b++;
        end
    end

    initial begin
        rst    = 1'b1;
        mask   = 4'b0000;
        data   = 32'h4433_2211;
        bright = 4'd4;
        #1 rst = 1'b0;
        step(2);
        chk_en = 1'b1;
        check("rst_cs_a",   cs_a,  4'b0000);
        check("rst_data_a", dat_a, 8'h00);
        check("rst_tick_a", tk_a,  1'b0);
        check("rst_cs_b",   cs_b,  4'b1111);

        // all four digits enabled
        rst  = 1'b1;
        mask = 4'b1111;
        step(3);
        check("d0_cs", cs_a, 4'b0001);
        check("d0_data", dat_a, 8'h11);
        check("al_d0_cs", cs_b, 4'b1110);
        step(10);
        check("d1_cs", cs_a, 4'b0010);
        check("d1_data", dat_a, 8'h22);
        step(10);
        check("d2_cs", cs_a, 4'b0100);
        check("d2_data", dat_a, 8'h33);
        step(10);
        check("d3_cs", cs_a, 4'b1000);
        check("d3_data", dat_a, 8'h44);
        step(8);
        check("wrap_tick", tk_a, 1'b1);
        t0 = ticks_a;
        step(40);
        check("ticks_per_40", ticks_a - t0, 1);

        // sparse mask: digits 1 and 3 only
        mask = 4'b1010;
        step(12);
        check("sparse_d1_cs", cs_a, 4'b0010);
        check("sparse_d1_data", dat_a, 8'h22);
        step(10);
        check("sparse_d3_cs", cs_a, 4'b1000);
        t0 = ticks_a;
        step(20);
        check("ticks_per_20", ticks_a - t0, 1);

        // mask cleared mid-slot, data changed mid-show
        mask = 4'b0000;
        data = 32'hA55A_C33C;
        step(7);
        check("slot_completes_cs", cs_a, 4'b1000);
        check("data_held", dat_a, 8'h44);
        step(1);
        check("idle_cs", cs_a, 4'b0000);
        check("idle_data", dat_a, 8'h00);
        check("idle_no_tick", tk_a, 1'b0);
        step(5);
        check("idle_stays", cs_a, 4'b0000);
        mask = 4'b0100;
        step(1);
        check("restart_blank", cs_a, 4'b0000);
        check("al_restart_cs", cs_b, 4'b1011);
        step(2);
        check("restart_cs", cs_a, 4'b0100);
        check("restart_data", dat_a, 8'h5A);

        // asynchronous reset at show cycle 3
        step(3);
        #2 rst = 1'b0;
        #1;
        check("async_cs_a", cs_a, 4'b0000);
        check("async_data_a", dat_a, 8'h00);
        check("async_cs_b", cs_b, 4'b1111);
        step(2);
        rst  = 1'b1;
        mask = 4'b0101;
        step(1);
        check("post_rst_idle_cs", cs_a, 4'b0000);
        step(2);
        check("post_rst_cs", cs_a, 4'b0001);
        check("post_rst_data", dat_a, 8'h3C);

`ifdef SEG_SCAN_BRIGHTNESS_EN
        step(8);
        t0 = act_a;
        begin
            int b0;
            b0 = act_b;
            step(10);
            check("bright4_on_a", act_a - t0, 4);
            check("bright4_on_b", act_b - b0, 4);
        end
        bright = 4'd0;
        step(10);
        t0 = act_a;
        begin
            int b0;
            b0 = act_b;
            step(10);
            check("bright0_on_a", act_a - t0, 0);
            check("bright0_on_b", act_b - b0, 0);
        end
`endif

        step(20);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
